// File: rtl/gpu_rect_engine_pkg.sv
// rtl/gpu_rect_engine_pkg.sv - shared op type, widths and helpers for the rectangle engine
package gpu_rect_engine_pkg;

  localparam int COLOR_W       = 12;
  localparam int SPRITE_ADDR_W = 16;
  localparam int COORD_W       = 11;

  typedef struct packed {
    logic [COORD_W-1:0]       x;
    logic [COORD_W-1:0]       y;
    logic [COORD_W-1:0]       width;
    logic [COORD_W-1:0]       height;
    logic [COLOR_W-1:0]       color;
    logic                     mem_en;
    logic [SPRITE_ADDR_W-1:0] mem_addr;
    logic                     scale;
  } gpu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } rect_state_t;

  // k is always a constant parameter, so this folds into a few shifted adds.
  function automatic logic [31:0] mul_const(input logic [COORD_W-1:0] a, input int k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + ({21'b0, a} << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gpu_rect_iter.sv
// rtl/gpu_rect_iter.sv - S0 pixel iterator: walks dx/dy row-major and tracks fb and texel addresses incrementally
module gpu_rect_iter
  import gpu_rect_engine_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int FB_ADDR_W         = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     step,
  input  logic                     fb_sel,
  input  logic [COORD_W-1:0]       op_x,
  input  logic [COORD_W-1:0]       op_y,
  input  logic [COORD_W-1:0]       op_w,
  input  logic [COORD_W-1:0]       op_h,
  input  logic [SPRITE_ADDR_W-1:0] op_mem_addr,
  input  logic                     op_scale,
  output logic [SPRITE_ADDR_W-1:0] sprite_addr,
  output logic [FB_ADDR_W-1:0]     fb_addr,
  output logic                     last,
  output logic                     clip
);

  localparam logic [FB_ADDR_W-1:0] BUF1_BASE = FB_ADDR_W'(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);
  localparam logic [FB_ADDR_W-1:0] ROW_STEP  = FB_ADDR_W'(HOR_ACTIVE_PIXELS);

  logic [COORD_W-1:0]       dx_q, dx_d, dy_q, dy_d;
  logic [COORD_W:0]         px_q, px_d, py_q, py_d;
  logic [FB_ADDR_W-1:0]     row_addr_q, row_addr_d, pix_addr_q, pix_addr_d;
  logic [SPRITE_ADDR_W-1:0] tex_row_q, tex_row_d, tex_addr_q, tex_addr_d;
  logic [SPRITE_ADDR_W-1:0] tex_stride;
  logic                     row_end;

  assign tex_stride = op_scale ? {6'b0, op_w[COORD_W-1:1]} : {5'b0, op_w};
  assign row_end    = (dx_q == op_w - 11'd1);

  always_comb begin
    dx_d       = dx_q;
    dy_d       = dy_q;
    px_d       = px_q;
    py_d       = py_q;
    row_addr_d = row_addr_q;
    pix_addr_d = pix_addr_q;
    tex_row_d  = tex_row_q;
    tex_addr_d = tex_addr_q;
    if (start) begin
      dx_d       = '0;
      dy_d       = '0;
      px_d       = {1'b0, op_x};
      py_d       = {1'b0, op_y};
      row_addr_d = (fb_sel ? BUF1_BASE : '0) + FB_ADDR_W'(mul_const(op_y, HOR_ACTIVE_PIXELS))
                   + FB_ADDR_W'(op_x);
      pix_addr_d = row_addr_d;
      tex_row_d  = op_mem_addr;
      tex_addr_d = op_mem_addr;
    end else if (step) begin
      if (row_end) begin
        dx_d       = '0;
        dy_d       = dy_q + 11'd1;
        px_d       = {1'b0, op_x};
        py_d       = py_q + 12'd1;
        row_addr_d = row_addr_q + ROW_STEP;
        pix_addr_d = row_addr_q + ROW_STEP;
        // With scale=1 each texel row is reused for two screen rows.
        if (!op_scale || dy_q[0]) tex_row_d = tex_row_q + tex_stride;
        tex_addr_d = tex_row_d;
      end else begin
        dx_d       = dx_q + 11'd1;
        px_d       = px_q + 12'd1;
        pix_addr_d = pix_addr_q + 1'b1;
        if (!op_scale || dx_q[0]) tex_addr_d = tex_addr_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_q       <= '0;
      dy_q       <= '0;
      px_q       <= '0;
      py_q       <= '0;
      row_addr_q <= '0;
      pix_addr_q <= '0;
      tex_row_q  <= '0;
      tex_addr_q <= '0;
    end else begin
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      px_q       <= px_d;
      py_q       <= py_d;
      row_addr_q <= row_addr_d;
      pix_addr_q <= pix_addr_d;
      tex_row_q  <= tex_row_d;
      tex_addr_q <= tex_addr_d;
    end
  end

  assign sprite_addr = tex_addr_q;
  assign fb_addr     = pix_addr_q;
  assign last        = row_end && (dy_q == op_h - 11'd1);
  assign clip        = (px_q >= 12'(HOR_ACTIVE_PIXELS)) || (py_q >= 12'(VER_ACTIVE_PIXELS));

endmodule

// File: rtl/gpu_rect_engine.sv
// rtl/gpu_rect_engine.sv - rectangle fill/blit engine: op FSM plus ROM-read and write pipeline stages
module gpu_rect_engine
  import gpu_rect_engine_pkg::*;
#(
  parameter int                 HOR_ACTIVE_PIXELS = 640,
  parameter int                 VER_ACTIVE_PIXELS = 480,
  parameter int                 FB_ADDR_W         = 20,
  parameter logic [COLOR_W-1:0] TRANSPARENT       = 12'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  gpu_op_t                  op,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic                     fb_sel,
  output logic [SPRITE_ADDR_W-1:0] sprite_addr,
  input  logic [COLOR_W-1:0]       sprite_data,
  output logic                     fb_wr_en,
  output logic [FB_ADDR_W-1:0]     fb_wr_addr,
  output logic [COLOR_W-1:0]       fb_wr_data
);

  rect_state_t          state_q, state_d;
  logic                 drain_q, drain_d;
  gpu_op_t              op_q, op_d, iter_op;
  logic                 s1_valid_q, s1_valid_d;
  logic [FB_ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic                 wr_en_q, wr_en_d;
  logic [FB_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [COLOR_W-1:0]   wr_data_q, wr_data_d;
  logic                 accept, it_last, it_clip;
  logic [FB_ADDR_W-1:0] it_fb_addr;

  assign accept  = ce && op_valid && (state_q == ST_IDLE);
  assign iter_op = accept ? op : op_q;

  gpu_rect_iter #(
    .HOR_ACTIVE_PIXELS(HOR_ACTIVE_PIXELS),
    .VER_ACTIVE_PIXELS(VER_ACTIVE_PIXELS),
    .FB_ADDR_W        (FB_ADDR_W)
  ) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (accept),
    .step       (ce && (state_q == ST_RUN)),
    .fb_sel     (fb_sel),
    .op_x       (iter_op.x),
    .op_y       (iter_op.y),
    .op_w       (iter_op.width),
    .op_h       (iter_op.height),
    .op_mem_addr(iter_op.mem_addr),
    .op_scale   (iter_op.scale),
    .sprite_addr(sprite_addr),
    .fb_addr    (it_fb_addr),
    .last       (it_last),
    .clip       (it_clip)
  );

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    op_d       = op_q;
    s1_valid_d = s1_valid_q;
    s1_addr_d  = s1_addr_q;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = op;
          drain_d = 1'b0;
          state_d = (op.width == '0 || op.height == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (ce && it_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ce) begin
          drain_d = !drain_q;
          if (drain_q) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // S1 carries the S0 pixel alongside the ROM read; S2 decides the write.
    if (ce) begin
      s1_valid_d = (state_q == ST_RUN) && !it_clip;
      s1_addr_d  = it_fb_addr;
      wr_en_d    = s1_valid_q && (!op_q.mem_en || sprite_data != TRANSPARENT);
      if (s1_valid_q) begin
        wr_addr_d = s1_addr_q;
        wr_data_d = op_q.mem_en ? sprite_data : op_q.color;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      drain_q    <= 1'b0;
      op_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      op_q       <= op_d;
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign op_ready   = (state_q == ST_IDLE);
  assign fb_wr_en   = wr_en_q;
  assign fb_wr_addr = wr_addr_q;
  assign fb_wr_data = wr_data_q;

endmodule

// File: tb/tb_gpu_rect_engine.sv
// tb/tb_gpu_rect_engine.sv - table-driven bench for gpu_rect_engine
module tb_gpu_rect_engine;
  import gpu_rect_engine_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, ce, op_valid, fb_sel;
  gpu_op_t     op;
  logic        op_ready, fb_wr_en;
  logic [15:0] sprite_addr;
  logic [11:0] sprite_data = '0;
  logic [19:0] fb_wr_addr;
  logic [11:0] fb_wr_data;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    gpu_op_t          o;
    logic             sel;
    int               n_wr;
    logic [0:7][19:0] addr;
    logic [0:7][11:0] data;
    int               ready_n;
    int               n_spr;
    logic [0:7][15:0] spr;
  } vec_t;

  vec_t vt[8];

  gpu_rect_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .op         (op),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .fb_sel     (fb_sel),
    .sprite_addr(sprite_addr),
    .sprite_data(sprite_data),
    .fb_wr_en   (fb_wr_en),
    .fb_wr_addr (fb_wr_addr),
    .fb_wr_data (fb_wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(input logic [15:0] a);
    return (a == 16'd1) ? 12'h000 : {a[7:0], 4'h5};
  endfunction

  always @(posedge clk) if (ce) sprite_data <= rom_f(sprite_addr);

  function automatic gpu_op_t mk(input int x, input int y, input int w, input int h,
                                 input int color, input logic mem_en, input int maddr,
                                 input logic scale);
    gpu_op_t o;
    o.x = 11'(x); o.y = 11'(y); o.width = 11'(w); o.height = 11'(h);
    o.color = 12'(color); o.mem_en = mem_en; o.mem_addr = 16'(maddr); o.scale = scale;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int n, nw, rn, wh;
    logic [19:0] ga[16];
    logic [11:0] gd[16];
    logic [15:0] gs[8];
    wh = int'(v.o.width) * int'(v.o.height);
    op = v.o; fb_sel = v.sel; op_valid = 1'b1;
    step();
    op_valid = 1'b0; op = '0;
    n = 1; nw = 0; rn = -1;
    while (n < 100) begin
      if (fb_wr_en) begin
        if (nw < 16) begin ga[nw] = fb_wr_addr; gd[nw] = fb_wr_data; end
        nw++;
      end
      if (n <= wh && n <= 8) gs[n-1] = sprite_addr;
      if (op_ready) begin rn = n; break; end
      step();
      n++;
    end
    chk($sformatf("v%0d_ready_cycle", idx), 32'(rn), 32'(v.ready_n));
    chk($sformatf("v%0d_write_count", idx), 32'(nw), 32'(v.n_wr));
    for (int k = 0; k < v.n_wr && k < nw && k < 8; k++) begin
      chk($sformatf("v%0d_addr%0d", idx, k), 32'(ga[k]), 32'(v.addr[k]));
      chk($sformatf("v%0d_data%0d", idx, k), 32'(gd[k]), 32'(v.data[k]));
    end
    for (int k = 0; k < v.n_spr; k++)
      chk($sformatf("v%0d_spr%0d", idx, k), 32'(gs[k]), 32'(v.spr[k]));
  endtask

  initial begin
    int n, nw, nce, it, extra;
    logic c;
    logic [19:0] ea[8];

    vt[0] = '{mk(0, 0, 4, 2, 12'hABC, 0, 0, 0), 1'b0, 8,
              {20'd0, 20'd1, 20'd2, 20'd3, 20'd640, 20'd641, 20'd642, 20'd643},
              {8{12'hABC}}, 11, 0, '0};
    vt[1] = '{mk(10, 5, 2, 2, 0, 1, 100, 0), 1'b1, 4,
              {20'd310410, 20'd310411, 20'd311050, 20'd311051, 80'd0},
              {12'h645, 12'h655, 12'h665, 12'h675, 48'd0}, 7, 4,
              {16'd100, 16'd101, 16'd102, 16'd103, 64'd0}};
    vt[2] = '{mk(0, 0, 4, 2, 0, 1, 0, 1), 1'b0, 4,
              {20'd0, 20'd1, 20'd640, 20'd641, 80'd0},
              {12'h005, 12'h005, 12'h005, 12'h005, 48'd0}, 11, 8,
              {16'd0, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd1, 16'd1}};
    vt[3] = '{mk(638, 479, 4, 2, 12'h123, 0, 0, 0), 1'b0, 2,
              {20'd307198, 20'd307199, 120'd0},
              {12'h123, 12'h123, 72'd0}, 11, 0, '0};
    vt[4] = '{mk(5, 5, 0, 3, 12'h321, 0, 0, 0), 1'b0, 0, '0, '0, 3, 0, '0};
    vt[5] = '{mk(5, 5, 5, 0, 12'h321, 0, 0, 0), 1'b1, 0, '0, '0, 3, 0, '0};
    vt[6] = '{mk(100, 0, 1, 1, 12'hFFF, 0, 0, 0), 1'b1, 1,
              {20'd307300, 140'd0}, {12'hFFF, 84'd0}, 4, 0, '0};
    vt[7] = '{mk(0, 480, 2, 1, 12'h0F0, 0, 0, 0), 1'b0, 0, '0, '0, 5, 0, '0};

    rst_n = 1'b0; ce = 1'b1; op_valid = 1'b0; op = '0; fb_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_fb_wr_en", 32'(fb_wr_en), 32'd0);
    chk("rst_fb_wr_addr", 32'(fb_wr_addr), 32'd0);
    chk("rst_fb_wr_data", 32'(fb_wr_data), 32'd0);
    chk("rst_sprite_addr", 32'(sprite_addr), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_op_ready", 32'(op_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_op(vt[i], i);
      step();
    end

    // op_valid while busy must be dropped, not queued
    op = mk(0, 10, 4, 1, 12'h111, 0, 0, 0); fb_sel = 1'b0; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    n = 1; nw = 0;
    while (n < 100 && !op_ready) begin
      if (fb_wr_en) begin
        chk($sformatf("busy_addr%0d", nw), 32'(fb_wr_addr), 32'(6400 + nw));
        chk($sformatf("busy_data%0d", nw), 32'(fb_wr_data), 32'h111);
        nw++;
      end
      op_valid = (n == 2);
      if (n == 2) op = mk(0, 20, 2, 2, 12'h222, 0, 0, 0);
      step();
      n++;
    end
    op_valid = 1'b0;
    chk("busy_ready_cycle", 32'(n), 32'd7);
    chk("busy_write_count", 32'(nw), 32'd4);
    extra = 0;
    repeat (12) begin
      step();
      if (fb_wr_en || !op_ready) extra++;
    end
    chk("busy_no_queued_op", 32'(extra), 32'd0);

    // ce toggling: outputs only advance on ce=1 cycles
    ea = '{20'd307200, 20'd307201, 20'd307202, 20'd307203,
           20'd307840, 20'd307841, 20'd307842, 20'd307843};
    op = mk(0, 0, 4, 2, 12'h5A5, 0, 0, 0); fb_sel = 1'b1; ce = 1'b1; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    nce = 1; it = 0;
    while (nce <= 12 && it < 200) begin
      chk($sformatf("ce_en_n%0d_i%0d", nce, it), 32'(fb_wr_en), 32'(nce >= 3 && nce <= 10));
      chk($sformatf("ce_ready_n%0d_i%0d", nce, it), 32'(op_ready), 32'(nce >= 11));
      if (nce >= 3 && nce <= 10) begin
        chk($sformatf("ce_addr_n%0d_i%0d", nce, it), 32'(fb_wr_addr), 32'(ea[nce-3]));
        chk($sformatf("ce_data_n%0d_i%0d", nce, it), 32'(fb_wr_data), 32'h5A5);
      end
      c = (it % 3 != 1);
      ce = c;
      step();
      if (c) nce++;
      it++;
    end
    chk("ce_loop_bound", 32'(nce > 12), 32'd1);
    ce = 1'b1;
    step();

    // asynchronous reset in the middle of RUN
    op = mk(0, 0, 8, 2, 12'h777, 0, 0, 0); fb_sel = 1'b0; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    repeat (4) step();
    chk("midrun_writing", 32'(fb_wr_en), 32'd1);
    chk("midrun_busy", 32'(op_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_op_ready", 32'(op_ready), 32'd1);
    chk("async_rst_fb_wr_en", 32'(fb_wr_en), 32'd0);
    chk("async_rst_fb_wr_addr", 32'(fb_wr_addr), 32'd0);
    chk("async_rst_fb_wr_data", 32'(fb_wr_data), 32'd0);
    chk("async_rst_sprite_addr", 32'(sprite_addr), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    extra = 0;
    repeat (25) begin
      step();
      if (fb_wr_en || !op_ready) extra++;
    end
    chk("post_abort_no_writes", 32'(extra), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
